mac_divider: RTL and testbench
==============================

// Module: mac_divider
// PURPOSE
// - Sequential radix-2 restoring divider; the inverse of the 16x16 MAC datapath (R = A*B + C).
// - Takes a 2N-bit product/accumulate result R and the N-bit multiplicand B.
// - Returns quotient Q (= A) and remainder Rem (= C, when C < B), one quotient bit per clock.
// - Used to check MAC results and to recover operands for error analysis of the approximate multiplier.
// PARAMETERS
// - INPUT_SIZE  16  operand width N; dividend is 2N bits, quotient/remainder N bits
// PORTS
// - clk       in   1     rising-edge clock; single clock domain
// - rst_n     in   1     asynchronous active-low reset
// - start     in   1     request; sampled on a rising edge when busy=0
// - R         in   2N    dividend; captured on the accepting edge
// - B         in   N     divisor; captured on the accepting edge
// - busy      out  1     1 while in CALC
// - done      out  1     1-cycle pulse; Q/Rem/flags valid from this cycle
// - Q         out  N     quotient
// - Rem       out  N     remainder
// - div_zero  out  1     B was 0
// - ovf       out  1     quotient does not fit in N bits (R[2N-1:N] >= B, B!=0)
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
// - Reset: rst_n=0 forces state IDLE and busy=done=div_zero=ovf=0, Q=Rem=0. Takes effect immediately, including mid-CALC; the operation in progress is discarded.
// - FSM states: IDLE, CALC, DONE.
//   - IDLE --start--> CALC, normal path.
//   - IDLE --start--> DONE, fast path when B==0 or R[2N-1:N]>=B.
//   - CALC --after N iterations--> DONE.
//   - DONE --no start--> IDLE.
//   - DONE --start--> CALC or DONE, same rules as from IDLE.
// - Acceptance: start is taken only when busy=0 (IDLE or DONE). start during CALC is ignored and not queued. R/B may change freely after the accepting edge.
// - On accept: div_zero and ovf are cleared, except that the fast path sets them.
// - Datapath: partial remainder prem is N+1 bits, initialised to {1'b0, R[2N-1:N]}. Shift register holds R[N-1:0].
// - Each CALC edge:
//   - trial = {prem[N-1:0], next dividend bit, MSB first}.
//   - If trial >= {1'b0,B}: prem = trial - B and the quotient bit is 1.
//   - Otherwise: prem = trial and the quotient bit is 0.
//   - The quotient shifts in from the LSB.
// - Exact integer division. No approximation is applied here, so the block also serves as golden reference against the approximate MAC.
// - Latency, normal path (accept at edge k):
//   - Iterations run on edges k+1..k+N.
//   - busy=1 in the cycles after edges k..k+N-1.
//   - done=1 and Q/Rem valid in the cycle after edge k+N.
// - Latency, fast path: done=1 in the cycle after edge k, busy never asserted.
// - Fast-path results: Q = {N{1'b1}}, Rem = R[N-1:0].
//   - div_zero=1 when B==0; ovf=0 in that case (div_zero has priority).
//   - Otherwise ovf=1.
// - Hold: Q, Rem, div_zero and ovf hold their value after done until the next accepted start. Q/Rem show intermediate values during CALC and must not be sampled until done.
// - Back-to-back: start in the DONE cycle is accepted. done is still 1 in that cycle; the new result follows after the normal or fast latency.
// TESTING
// 1. R=0x0000_0C35, B=0x0019 -> Q=0x007D, Rem=0x0000, ovf=div_zero=0. done exactly N=16 cycles after the accept edge.
// 2. MAC inverse: R=0x0006_1D89 (0x1234*0x56+0x11), B=0x0056 -> Q=0x1234, Rem=0x0011.
// 3. Max operands: R=0xFFFE_0001, B=0xFFFF -> Q=0xFFFF, Rem=0x0000, ovf=0.
// 4. Divide by zero: R=0x1234_5678, B=0 -> done 1 cycle after accept, busy=0 throughout, Q=0xFFFF, Rem=0x5678, div_zero=1, ovf=0.
// 5. Overflow: R=0x0056_0000, B=0x0056 -> fast path, Q=0xFFFF, Rem=0x0000, ovf=1.
//    Then start case 1 in the done cycle -> ovf cleared on accept, case 1 result 16 cycles later.
// 6. Robustness:
//    - start pulse and changed R/B during CALC -> ignored, result still matches the original request.
//    - rst_n low at iteration 8 -> all outputs 0 immediately, state IDLE, next start runs cleanly.

Source files
------------

// File: rtl/mac_divider.sv
// Sequential radix-2 restoring divider: R (2N bits) / B (N bits) -> Q, Rem, one quotient bit per clock.
// Undoes the MAC result R = A*B + C. Quotient overflow and divide-by-zero skip the iterations entirely.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one quotient bit per edge
// DONE  | result valid, done pulse; start here is accepted

module mac_divider #(
   parameter int INPUT_SIZE = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [2*INPUT_SIZE-1:0]   R,
   input  logic [INPUT_SIZE-1:0]     B,
   output logic                      busy,
   output logic                      done,
   output logic [INPUT_SIZE-1:0]     Q,
   output logic [INPUT_SIZE-1:0]     Rem,
   output logic                      div_zero,
   output logic                      ovf
);

   localparam int N  = INPUT_SIZE;
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state, state_nxt;
   logic [N:0]     prem;
   logic [N-1:0]   shreg;
   logic [N-1:0]   divisor;
   logic [CW-1:0]  cnt;
   logic           accept, fast, last, qbit;
   logic [N:0]     trial, diff;

   assign accept = start && (state != CALC);
   assign fast   = (B == '0) || (R[2*N-1:N] >= B);
   assign last   = (cnt == '0);

   // shreg shifts dividend bits out of the MSB while quotient bits enter at the LSB
   assign trial = {prem[N-1:0], shreg[N-1]};
   assign qbit  = prem[N] || (trial >= {1'b0, divisor});
   assign diff  = trial - {1'b0, divisor};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = fast ? DONE : CALC;
         CALC: if (last)  state_nxt = DONE;
         DONE: begin
            if (start) state_nxt = fast ? DONE : CALC;
            else       state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prem     <= '0;
         shreg    <= '0;
         divisor  <= '0;
         cnt      <= '0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
      end else if (accept) begin
         divisor <= B;
         cnt     <= CW'(N - 1);
         if (fast) begin
            shreg    <= '1;
            prem     <= {1'b0, R[N-1:0]};
            div_zero <= (B == '0);
            ovf      <= (B != '0);
         end else begin
            shreg    <= R[N-1:0];
            prem     <= {1'b0, R[2*N-1:N]};
            div_zero <= 1'b0;
            ovf      <= 1'b0;
         end
      end else if (state == CALC) begin
         prem  <= qbit ? diff : trial;
         shreg <= {shreg[N-2:0], qbit};
         cnt   <= cnt - 1'b1;
      end
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);
   assign Q    = shreg;
   assign Rem  = prem[N-1:0];

endmodule

// File: tb/tb_mac_divider.sv
// Scoreboard bench for mac_divider: stimulus pushes expected results computed with plain
// integer division; a negedge monitor pops and compares whenever done is high.

module tb_mac_divider;

   localparam int N = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   R = '0;
   logic [15:0]   B = '0;
   logic          busy, done, div_zero, ovf;
   logic [15:0]   Q, Rem;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] q;
      logic [15:0] rem;
      logic        dz;
      logic        ov;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   next_id = 0;

   mac_divider #(.INPUT_SIZE(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .R        (R),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .Q        (Q),
      .Rem      (Rem),
      .div_zero (div_zero),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (txn %0d): got 0x%0h expected 0x%0h", nm, id, act, exp);
      end
   endtask

   // Reference: exact integer division; a quotient above 16 bits or B=0 gives the saturated result.
   function automatic exp_t model(input logic [31:0] r, input logic [15:0] b, input int c_now);
      exp_t e;
      longint unsigned qq;
      e.id = 0;
      if (b == 0) begin
         e.q = 16'hFFFF; e.rem = r[15:0]; e.dz = 1'b1; e.ov = 1'b0; e.cyc = c_now + 1;
      end else begin
         qq = longint'(r) / longint'(b);
         if (qq > 65535) begin
            e.q = 16'hFFFF; e.rem = r[15:0]; e.dz = 1'b0; e.ov = 1'b1; e.cyc = c_now + 1;
         end else begin
            e.q = qq[15:0];
            e.rem = 16'(longint'(r) % longint'(b));
            e.dz = 1'b0; e.ov = 1'b0; e.cyc = c_now + 1 + N;
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", -1, 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("Q", e.id, 32'(Q), 32'(e.q));
            chk("Rem", e.id, 32'(Rem), 32'(e.rem));
            chk("div_zero", e.id, 32'(div_zero), 32'(e.dz));
            chk("ovf", e.id, 32'(ovf), 32'(e.ov));
            chk("done_cycle", e.id, 32'(cyc), 32'(e.cyc));
            chk("busy_at_done", e.id, 32'(busy), 32'd0);
         end
      end
   end

   // Call at a negedge; returns at the following negedge. push=0 issues without expecting a result.
   task automatic issue(input logic [31:0] r, input logic [15:0] b, input bit push);
      exp_t e;
      e = model(r, b, cyc);
      e.id = next_id++;
      R = r; B = b; start = 1'b1;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      R = $urandom; B = 16'($urandom);
      chk("busy_after_accept", e.id, 32'(busy), (e.cyc == cyc + N) ? 32'd1 : 32'd0);
      @(negedge clk);
   endtask

   task automatic drain();
      int budget = 200;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", -1, 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic wait_done();
      int budget = 200;
      while (!done && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (!done) chk("wait_done_timeout", -1, 32'(done), 32'd1);
   endtask

   initial begin
      logic [31:0] r;
      logic [15:0] b, a, c;
      int kind;

      #3;
      chk("reset_busy", -1, 32'(busy), 32'd0);
      chk("reset_done", -1, 32'(done), 32'd0);
      chk("reset_Q", -1, 32'(Q), 32'd0);
      chk("reset_Rem", -1, 32'(Rem), 32'd0);
      chk("reset_flags", -1, 32'({div_zero, ovf}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      issue(32'h0000_0C35, 16'h0019, 1); drain();
      issue(32'h0006_1D89, 16'h0056, 1); drain();
      issue(32'hFFFE_0001, 16'hFFFF, 1); drain();
      issue(32'h1234_5678, 16'h0000, 1); drain();

      // overflow, then a normal request in its done cycle
      issue(32'h0056_0000, 16'h0056, 1);
      wait_done();
      issue(32'h0000_0C35, 16'h0019, 1);
      drain();

      // start with new operands during CALC must be ignored
      issue(32'h0006_1D89, 16'h0056, 1);
      repeat (4) @(negedge clk);
      R = 32'h0000_0C35; B = 16'h0019; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // reset at iteration 8
      issue(32'h0006_1D89, 16'h0056, 0);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_busy", -1, 32'(busy), 32'd0);
      chk("midreset_done", -1, 32'(done), 32'd0);
      chk("midreset_Q", -1, 32'(Q), 32'd0);
      chk("midreset_Rem", -1, 32'(Rem), 32'd0);
      chk("midreset_flags", -1, 32'({div_zero, ovf}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      issue(32'h0000_0C35, 16'h0019, 1); drain();

      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 5);
         b = 16'($urandom);
         a = 16'($urandom);
         case (kind)
            0, 1: begin
               if (b == 0) b = 16'd1;
               c = 16'($urandom_range(0, int'(b) - 1));
               r = a * b + c;
            end
            2: begin b = 16'd0; r = $urandom; end
            3: begin
               b = 16'($urandom_range(1, 255));
               c = 16'($urandom_range(0, int'(b) - 1));
               r = a * b + c;
            end
            default: r = $urandom;
         endcase
         issue(r, b, 1);
         case ($urandom_range(0, 2))
            0: wait_done();
            1: drain();
            default: begin drain(); repeat ($urandom_range(0, 3)) @(negedge clk); end
         endcase
      end
      drain();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
